// File: rtl/stage4_memory_pkg.sv
// -----------------------------------------------------------------------------
// common -- shared types and constants for the stage4_memory pipeline stage.
//
// Contents:
//   REGISTER_WIDTH          datapath width (32)
//   OP_*                    opcodes the memory stage distinguishes
//   load_funct3_e           LB/LH/LW/LBU/LHU encodings
//   store_funct3_e          SB/SH/SW encodings
//   decoded_instruction_t   instruction fields carried down the pipe
//   execute_to_memory_t     upstream stream payload
//   memory_to_writeback_t   downstream stream payload
//   ST_*                    memory-stage FSM state encodings
//   is_mem_opcode()         true for load/store opcodes
// -----------------------------------------------------------------------------
package common;

   localparam int REGISTER_WIDTH = 32;

   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_ALU     = 7'b0110011;
   localparam logic [6:0] OP_ALU_IMM = 7'b0010011;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_e;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_e;

   typedef struct packed {
      logic [6:0]                opcode;
      logic [2:0]                funct3;
      logic [4:0]                rd;
      logic [REGISTER_WIDTH-1:0] immediate;
   } decoded_instruction_t;

   localparam int DECODED_W = $bits(decoded_instruction_t);

   typedef struct packed {
      decoded_instruction_t      decoded_instruction;
      logic [REGISTER_WIDTH-1:0] rs1_value;
      logic [REGISTER_WIDTH-1:0] rs2_value;
      logic [REGISTER_WIDTH-1:0] alu_result;
      logic                      branch_taken;
      logic [REGISTER_WIDTH-1:0] branch_target;
   } execute_to_memory_t;

   typedef struct packed {
      decoded_instruction_t      decoded_instruction;
      logic [REGISTER_WIDTH-1:0] result;
      logic                      misaligned;
   } memory_to_writeback_t;

   // Memory-stage FSM encodings
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_REQ      = 2'd1;
   localparam logic [1:0] ST_WAIT_RSP = 2'd2;
   localparam logic [1:0] ST_OUT      = 2'd3;

   function automatic logic is_mem_opcode(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/stage4_memory_align.sv
// -----------------------------------------------------------------------------
// load_store_align -- combinational byte-lane steering for loads and stores.
//
// Ports:
//   addr_lo     in  2   effective address bits [1:0]
//   funct3      in  3   load or store width/sign selector
//   is_store    in  1   1 = interpret funct3 as a store encoding
//   store_data  in  32  rs2 value to be written
//   load_data   in  32  word returned by data memory
//   wdata       out 32  store data replicated across lanes
//   wstrb       out 4   byte enables for the store
//   rdata_ext   out 32  selected load lane, sign/zero extended
//   misaligned  out 1   access crosses its natural alignment
//   funct3_ok   out 1   funct3 is a defined encoding for this access
// -----------------------------------------------------------------------------
module load_store_align
   import common::*;
(
   input  logic [1:0]                addr_lo,
   input  logic [2:0]                funct3,
   input  logic                      is_store,
   input  logic [REGISTER_WIDTH-1:0] store_data,
   input  logic [REGISTER_WIDTH-1:0] load_data,
   output logic [REGISTER_WIDTH-1:0] wdata,
   output logic [3:0]                wstrb,
   output logic [REGISTER_WIDTH-1:0] rdata_ext,
   output logic                      misaligned,
   output logic                      funct3_ok
);

   logic [REGISTER_WIDTH-1:0] byte_shift;
   logic [REGISTER_WIDTH-1:0] half_shift;
   logic [7:0]                lane_byte;
   logic [15:0]               lane_half;

   // Bring the addressed lane down to bit 0; halfwords use addr_lo[1] only.
   assign byte_shift = load_data >> {addr_lo, 3'b000};
   assign half_shift = load_data >> {addr_lo[1], 4'b0000};
   assign lane_byte  = byte_shift[7:0];
   assign lane_half  = half_shift[15:0];

   always_comb begin
      wdata      = '0;
      wstrb      = 4'b0000;
      rdata_ext  = '0;
      misaligned = 1'b0;
      funct3_ok  = 1'b0;
      if (is_store) begin
         case (funct3)
            SB: begin
               funct3_ok = 1'b1;
               wdata     = {4{store_data[7:0]}};
               wstrb     = 4'b0001 << addr_lo;
            end
            SH: begin
               funct3_ok  = 1'b1;
               misaligned = addr_lo[0];
               wdata      = {2{store_data[15:0]}};
               wstrb      = 4'b0011 << addr_lo;
            end
            SW: begin
               funct3_ok  = 1'b1;
               misaligned = (addr_lo != 2'b00);
               wdata      = store_data;
               wstrb      = 4'b1111;
            end
            default: funct3_ok = 1'b0;
         endcase
      end else begin
         case (funct3)
            LB: begin
               funct3_ok = 1'b1;
               rdata_ext = {{24{lane_byte[7]}}, lane_byte};
            end
            LH: begin
               funct3_ok  = 1'b1;
               misaligned = addr_lo[0];
               rdata_ext  = {{16{lane_half[15]}}, lane_half};
            end
            LW: begin
               funct3_ok  = 1'b1;
               misaligned = (addr_lo != 2'b00);
               rdata_ext  = load_data;
            end
            LBU: begin
               funct3_ok = 1'b1;
               rdata_ext = {24'd0, lane_byte};
            end
            LHU: begin
               funct3_ok  = 1'b1;
               misaligned = addr_lo[0];
               rdata_ext  = {16'd0, lane_half};
            end
            default: funct3_ok = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/stage4_memory.sv
// -----------------------------------------------------------------------------
// stage4_memory -- pipeline memory stage between execute and writeback.
//
// Non-memory instructions pass alu_result through with one cycle of latency at
// full throughput. Aligned loads/stores issue a single data-memory request and
// hold the stage until the access completes; misaligned ones complete at once
// with misaligned=1 and no memory traffic.
//
// Stream handshakes (both axis ports): a beat transfers on a rising edge where
// tvalid and tready are both 1. Once tvalid is raised the payload is held
// constant until that transfer; tready may depend on the other side's tvalid.
// dmem_req_* follows the same rule; dmem_rsp_valid is a one-cycle strobe with
// no back-pressure.
//
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   axis_execute_to_memory_*                  upstream stream (in)
//   axis_memory_to_writeback_*                downstream stream (out)
//   dmem_req_valid/ready/write/addr/wdata/wstrb   data-memory request
//   dmem_rsp_valid/rdata                      data-memory load response
//   dbg_state                                 current FSM state (ST_* encoding)
// -----------------------------------------------------------------------------
module stage4_memory
   import common::*;
(
   input  logic                      clk,
   input  logic                      rst,
   // upstream
   input  logic                      axis_execute_to_memory_tvalid,
   output logic                      axis_execute_to_memory_tready,
   input  logic [DECODED_W-1:0]      axis_execute_to_memory_decoded_instruction,
   input  logic [REGISTER_WIDTH-1:0] axis_execute_to_memory_rs1_value,
   input  logic [REGISTER_WIDTH-1:0] axis_execute_to_memory_rs2_value,
   input  logic [REGISTER_WIDTH-1:0] axis_execute_to_memory_alu_result,
   input  logic                      axis_execute_to_memory_branch_taken,
   input  logic [REGISTER_WIDTH-1:0] axis_execute_to_memory_branch_target,
   // downstream
   output logic                      axis_memory_to_writeback_tvalid,
   input  logic                      axis_memory_to_writeback_tready,
   output logic [DECODED_W-1:0]      axis_memory_to_writeback_decoded_instruction,
   output logic [REGISTER_WIDTH-1:0] axis_memory_to_writeback_result,
   output logic                      axis_memory_to_writeback_misaligned,
   // data memory
   output logic                      dmem_req_valid,
   input  logic                      dmem_req_ready,
   output logic                      dmem_req_write,
   output logic [REGISTER_WIDTH-1:0] dmem_req_addr,
   output logic [REGISTER_WIDTH-1:0] dmem_req_wdata,
   output logic [3:0]                dmem_req_wstrb,
   input  logic                      dmem_rsp_valid,
   input  logic [REGISTER_WIDTH-1:0] dmem_rsp_rdata,
   // debug
   output logic [1:0]                dbg_state
);

   // ---------------------------------------------------------------- state
   logic [1:0]                state_q, state_d;
   logic                      out_valid_q, out_valid_d;
   memory_to_writeback_t      out_q, out_d;
   logic                      req_write_q, req_write_d;
   logic [REGISTER_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [REGISTER_WIDTH-1:0] req_wdata_q, req_wdata_d;
   logic [3:0]                req_wstrb_q, req_wstrb_d;
   logic [1:0]                addr_lo_q, addr_lo_d;

   // ---------------------------------------------------------------- decode
   decoded_instruction_t      instr_in;
   logic [REGISTER_WIDTH-1:0] eff_addr;
   logic                      in_is_store;
   logic                      in_is_mem;
   logic                      in_tready;
   logic                      accept;
   logic                      unused_branch;

   assign instr_in    = axis_execute_to_memory_decoded_instruction;
   assign eff_addr    = axis_execute_to_memory_rs1_value + instr_in.immediate;
   assign in_is_store = (instr_in.opcode == OP_STORE);
   assign in_is_mem   = is_mem_opcode(instr_in.opcode);

   // Branch information is resolved upstream; this stage only forwards results.
   assign unused_branch = ^{axis_execute_to_memory_branch_taken,
                            axis_execute_to_memory_branch_target};

   // Accept only when idle and the output slot is empty or draining this cycle.
   assign in_tready = (state_q == ST_IDLE) &&
                      (!out_valid_q || axis_memory_to_writeback_tready);
   assign accept    = axis_execute_to_memory_tvalid && in_tready;

   // ---------------------------------------------------------------- lanes
   // One aligner serves both directions: in IDLE it sees the incoming
   // instruction (store data, legality), afterwards it sees the held access
   // so the load response can be extended with the original lane and funct3.
   logic                      idle;
   logic [1:0]                al_addr_lo;
   logic [2:0]                al_funct3;
   logic                      al_is_store;
   logic [REGISTER_WIDTH-1:0] al_wdata;
   logic [3:0]                al_wstrb;
   logic [REGISTER_WIDTH-1:0] al_rdata_ext;
   logic                      al_misaligned;
   logic                      al_funct3_ok;

   assign idle        = (state_q == ST_IDLE);
   assign al_addr_lo  = idle ? eff_addr[1:0]   : addr_lo_q;
   assign al_funct3   = idle ? instr_in.funct3 : out_q.decoded_instruction.funct3;
   assign al_is_store = idle ? in_is_store     : req_write_q;

   load_store_align u_align (
      .addr_lo    (al_addr_lo),
      .funct3     (al_funct3),
      .is_store   (al_is_store),
      .store_data (axis_execute_to_memory_rs2_value),
      .load_data  (dmem_rsp_rdata),
      .wdata      (al_wdata),
      .wstrb      (al_wstrb),
      .rdata_ext  (al_rdata_ext),
      .misaligned (al_misaligned),
      .funct3_ok  (al_funct3_ok)
   );

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      req_write_d = req_write_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wstrb_d = req_wstrb_q;
      addr_lo_d   = addr_lo_q;

      case (state_q)
         ST_IDLE: begin
            if (out_valid_q && axis_memory_to_writeback_tready) begin
               out_valid_d = 1'b0;
            end
            if (accept) begin
               out_d.decoded_instruction = instr_in;
               out_d.misaligned          = 1'b0;
               out_d.result              = axis_execute_to_memory_alu_result;
               out_valid_d               = 1'b1;
               if (in_is_mem) begin
                  // Memory opcodes never report alu_result; undefined
                  // encodings and misaligned accesses complete with 0.
                  out_d.result = '0;
                  if (al_funct3_ok && al_misaligned) begin
                     out_d.misaligned = 1'b1;
                  end else if (al_funct3_ok) begin
                     out_valid_d = 1'b0;
                     state_d     = ST_REQ;
                     req_write_d = in_is_store;
                     req_addr_d  = {eff_addr[REGISTER_WIDTH-1:2], 2'b00};
                     req_wdata_d = in_is_store ? al_wdata : '0;
                     req_wstrb_d = in_is_store ? al_wstrb : 4'b0000;
                     addr_lo_d   = eff_addr[1:0];
                  end
               end
            end
         end

         ST_REQ: begin
            // Any response strobe here predates the handshake and is dropped.
            if (dmem_req_ready) begin
               if (req_write_q) begin
                  state_d      = ST_OUT;
                  out_valid_d  = 1'b1;
                  out_d.result = '0;
               end else begin
                  state_d = ST_WAIT_RSP;
               end
            end
         end

         ST_WAIT_RSP: begin
            if (dmem_rsp_valid) begin
               state_d      = ST_OUT;
               out_valid_d  = 1'b1;
               out_d.result = al_rdata_ext;
            end
         end

         ST_OUT: begin
            if (axis_memory_to_writeback_tready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wstrb_q <= 4'b0000;
         addr_lo_q   <= 2'b00;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         req_write_q <= req_write_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wstrb_q <= req_wstrb_d;
         addr_lo_q   <= addr_lo_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign axis_execute_to_memory_tready                = in_tready;
   assign axis_memory_to_writeback_tvalid              = out_valid_q;
   assign axis_memory_to_writeback_decoded_instruction = out_q.decoded_instruction;
   assign axis_memory_to_writeback_result              = out_q.result;
   assign axis_memory_to_writeback_misaligned          = out_q.misaligned;

   assign dmem_req_valid = (state_q == ST_REQ);
   assign dmem_req_write = req_write_q;
   assign dmem_req_addr  = req_addr_q;
   assign dmem_req_wdata = req_wdata_q;
   assign dmem_req_wstrb = req_wstrb_q;

   assign dbg_state = state_q;

endmodule

// File: tb/tb_stage4_memory.sv
module tb_stage4_memory;
   import common::*;

   // ------------------------------------------------------------ clock/reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                 in_tvalid = 1'b0, in_tready;
   logic [DECODED_W-1:0] in_instr = '0;
   logic [31:0]          rs1 = '0, rs2 = '0, alu = '0, br_target = '0;
   logic                 br_taken = 1'b0;
   logic                 out_tvalid, out_tready = 1'b0, out_mis;
   logic [DECODED_W-1:0] out_instr;
   logic [31:0]          out_result;
   logic                 req_valid, req_ready = 1'b0, req_write;
   logic [31:0]          req_addr, req_wdata, rsp_rdata = '0;
   logic [3:0]           req_wstrb;
   logic                 rsp_valid = 1'b0;
   logic [1:0]           dbg_state;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   stage4_memory dut (
      .clk(clk), .rst(rst),
      .axis_execute_to_memory_tvalid(in_tvalid),
      .axis_execute_to_memory_tready(in_tready),
      .axis_execute_to_memory_decoded_instruction(in_instr),
      .axis_execute_to_memory_rs1_value(rs1),
      .axis_execute_to_memory_rs2_value(rs2),
      .axis_execute_to_memory_alu_result(alu),
      .axis_execute_to_memory_branch_taken(br_taken),
      .axis_execute_to_memory_branch_target(br_target),
      .axis_memory_to_writeback_tvalid(out_tvalid),
      .axis_memory_to_writeback_tready(out_tready),
      .axis_memory_to_writeback_decoded_instruction(out_instr),
      .axis_memory_to_writeback_result(out_result),
      .axis_memory_to_writeback_misaligned(out_mis),
      .dmem_req_valid(req_valid), .dmem_req_ready(req_ready),
      .dmem_req_write(req_write), .dmem_req_addr(req_addr),
      .dmem_req_wdata(req_wdata), .dmem_req_wstrb(req_wstrb),
      .dmem_rsp_valid(rsp_valid), .dmem_rsp_rdata(rsp_rdata),
      .dbg_state(dbg_state)
   );

   // ------------------------------------------------------------ types
   typedef struct {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [31:0] imm, rs1, rs2, alu, rdata;
      int          req_delay, rsp_delay, out_stall;
   } txn_t;

   typedef struct {
      bit                   accepted, got_req, got_out, stable_ok, tready_ok, drop_ok;
      logic                 req_write, out_mis;
      logic [31:0]          req_addr, req_wdata, out_result;
      logic [3:0]           req_wstrb;
      logic [DECODED_W-1:0] out_instr;
      int                   out_lat;
   } obs_t;

   typedef struct {
      bit          req, write, mis;
      logic [31:0] addr, wdata, result;
      logic [3:0]  wstrb;
      int          lat;
   } exp_t;

   function automatic logic [DECODED_W-1:0] pack(input txn_t t);
      decoded_instruction_t d;
      d.opcode    = t.opcode;
      d.funct3    = t.funct3;
      d.rd        = 5'd7;
      d.immediate = t.imm;
      return d;
   endfunction

   function automatic txn_t mk(input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] r1, input logic [31:0] im,
                               input logic [31:0] r2, input logic [31:0] a);
      txn_t t;
      t.opcode = op; t.funct3 = f3; t.rs1 = r1; t.imm = im; t.rs2 = r2; t.alu = a;
      t.rdata = 32'h0; t.req_delay = 0; t.rsp_delay = 1; t.out_stall = 0;
      return t;
   endfunction

   // ------------------------------------------------------------ reference model
   // Works from access size and byte offset: which bytes move, where they land.
   function automatic exp_t model(input txn_t t);
      exp_t        e;
      logic [31:0] addr, v, m;
      int          size, off, strb;
      bit          is_ld, is_st, legal;
      e = '{default: 0};
      e.lat = 1;
      addr  = t.rs1 + t.imm;
      off   = int'(addr % 4);
      is_ld = (t.opcode == OP_LOAD);
      is_st = (t.opcode == OP_STORE);
      if (!is_ld && !is_st) begin
         e.result = t.alu;
         return e;
      end
      legal = is_ld ? (t.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (t.funct3 <= 3'd2);
      if (!legal) return e;
      size = 1 << t.funct3[1:0];
      if (off % size != 0) begin
         e.mis = 1;
         return e;
      end
      e.req   = 1;
      e.write = is_st;
      e.addr  = addr - 32'(off);
      if (is_st) begin
         for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = t.rs2[8*(i % size) +: 8];
         strb    = ((1 << size) - 1) << off;
         e.wstrb = strb[3:0];
         e.lat   = t.req_delay + 2;
      end else begin
         v = t.rdata >> (8 * off);
         if (size < 4) begin
            m = (32'd1 << (8 * size)) - 32'd1;
            v = v & m;
            if (t.funct3[2] == 1'b0 && v[8*size-1]) v = v | ~m;
         end
         e.result = v;
         e.lat    = t.req_delay + t.rsp_delay + 2;
      end
      return e;
   endfunction

   // ------------------------------------------------------------ driver
   // Issues one instruction, plays data memory and the writeback consumer,
   // and records what the DUT did. Garbage responses are driven whenever a
   // request is pending so an early response would corrupt the result.
   task automatic run_txn(input txn_t t, output obs_t o);
      int  req_cyc, rsp_k, out_cyc;
      bit  hs_done, hs_now, out_hs, done;
      o = '{default: 0};
      o.stable_ok = 1; o.tready_ok = 1; o.drop_ok = 1;
      @(negedge clk);
      in_instr = pack(t); rs1 = t.rs1; rs2 = t.rs2; alu = t.alu;
      br_taken = 1'($urandom); br_target = $urandom;
      in_tvalid = 1'b1; out_tready = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0;
      repeat (20) begin
         #1;
         if (in_tready) begin
            o.accepted = 1;
            break;
         end
         @(negedge clk);
      end
      if (!o.accepted) begin
         in_tvalid = 1'b0;
         return;
      end
      @(negedge clk);
      in_tvalid = 1'b0;
      req_cyc = 0; rsp_k = 0; out_cyc = 0; hs_done = 0; done = 0;
      for (int c = 1; c <= 80 && !done; c++) begin
         hs_now = 0; out_hs = 0;
         req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = $urandom; out_tready = 1'b0;
         if (req_valid) begin
            if (!o.got_req) begin
               o.got_req = 1; o.req_write = req_write; o.req_addr = req_addr;
               o.req_wdata = req_wdata; o.req_wstrb = req_wstrb;
            end else if ({req_write, req_addr, req_wdata, req_wstrb} !==
                         {o.req_write, o.req_addr, o.req_wdata, o.req_wstrb}) begin
               o.stable_ok = 0;
            end
            req_ready = (req_cyc >= t.req_delay);
            hs_now    = req_ready;
            rsp_valid = 1'b1;
            req_cyc++;
         end else if (hs_done) begin
            rsp_k++;
            if (rsp_k == t.rsp_delay) begin
               rsp_valid = 1'b1;
               rsp_rdata = t.rdata;
            end
         end
         if (out_tvalid) begin
            if (!o.got_out) begin
               o.got_out = 1; o.out_lat = c; o.out_result = out_result;
               o.out_mis = out_mis; o.out_instr = out_instr;
            end else if ({out_result, out_mis, out_instr} !== {o.out_result, o.out_mis, o.out_instr}) begin
               o.stable_ok = 0;
            end
            out_tready = (out_cyc >= t.out_stall);
            out_hs     = out_tready;
            out_cyc++;
         end
         #1;
         if (in_tready && (req_valid || (out_tvalid && !out_tready) || (hs_done && !o.got_out)))
            o.tready_ok = 0;
         @(posedge clk);
         if (hs_now) hs_done = 1;
         @(negedge clk);
         if (out_hs) begin
            o.drop_ok = !out_tvalid;
            done = 1;
         end
      end
      req_ready = 1'b0; rsp_valid = 1'b0;
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({out_tvalid, req_valid, req_write, req_wstrb, out_mis} !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: got tv=%b rv=%b wr=%b strb=%b mis=%b need all 0",
                  out_tvalid, req_valid, req_write, req_wstrb, out_mis);
      end
      checks++;
      if (dbg_state !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_state: got %0d need %0d", dbg_state, ST_IDLE);
      end
      rst = 1'b0;
      out_tready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_tready !== 1'b1) begin
         failures++;
         $display("FAIL reset_tready: got %b need 1", in_tready);
      end
   endtask

   task automatic test_add();
      txn_t t; obs_t o;
      t = mk(OP_ALU, 3'b000, 32'h5, 32'h0, 32'hD, 32'h12);
      run_txn(t, o);
      checks++;
      if (!o.got_out || o.out_result !== 32'h12 || o.out_lat != 1 || o.out_mis !== 1'b0) begin
         failures++;
         $display("FAIL add_result: got out=%0d res=%h lat=%0d mis=%b need res=00000012 lat=1 mis=0",
                  o.got_out, o.out_result, o.out_lat, o.out_mis);
      end
      checks++;
      if (o.got_req || !o.drop_ok) begin
         failures++;
         $display("FAIL add_no_req: got req=%0d drop_ok=%0d need req=0 drop_ok=1", o.got_req, o.drop_ok);
      end
   endtask

   task automatic test_sb();
      txn_t t; obs_t o;
      t = mk(OP_STORE, 3'b000, 32'h100, 32'h3, 32'hAB, 32'hFFFF);
      run_txn(t, o);
      checks++;
      if (!o.got_req || o.req_write !== 1'b1 || o.req_addr !== 32'h100 ||
          o.req_wstrb !== 4'b1000 || o.req_wdata !== 32'hABABABAB) begin
         failures++;
         $display("FAIL sb_request: got req=%0d wr=%b addr=%h strb=%b wdata=%h need 1 1 00000100 1000 abababab",
                  o.got_req, o.req_write, o.req_addr, o.req_wstrb, o.req_wdata);
      end
      checks++;
      if (!o.got_out || o.out_result !== 32'h0 || o.out_lat != 2) begin
         failures++;
         $display("FAIL sb_output: got out=%0d res=%h lat=%0d need res=0 lat=2", o.got_out, o.out_result, o.out_lat);
      end
   endtask

   task automatic test_lb_lbu();
      txn_t t; obs_t o;
      logic [31:0] need [2];
      need[0] = 32'hFFFFFF80;
      need[1] = 32'h00000080;
      for (int k = 0; k < 2; k++) begin
         t = mk(OP_LOAD, (k == 0) ? 3'b000 : 3'b100, 32'h200, 32'h2, 32'h0, 32'h77);
         t.rdata = 32'h00800000; t.rsp_delay = 3;
         run_txn(t, o);
         checks++;
         if (!o.got_req || o.req_write !== 1'b0 || o.req_addr !== 32'h200 || o.req_wstrb !== 4'b0000) begin
            failures++;
            $display("FAIL lb_request[%0d]: got req=%0d wr=%b addr=%h strb=%b need 1 0 00000200 0000",
                     k, o.got_req, o.req_write, o.req_addr, o.req_wstrb);
         end
         checks++;
         if (!o.got_out || o.out_result !== need[k] || o.out_lat != 5) begin
            failures++;
            $display("FAIL lb_result[%0d]: got res=%h lat=%0d need res=%h lat=5", k, o.out_result, o.out_lat, need[k]);
         end
      end
   endtask

   task automatic test_misaligned();
      txn_t t; obs_t o;
      t = mk(OP_LOAD, 3'b010, 32'h100, 32'h1, 32'h0, 32'h99);
      run_txn(t, o);
      checks++;
      if (o.got_req || !o.got_out || o.out_mis !== 1'b1 || o.out_result !== 32'h0 || o.out_lat != 1) begin
         failures++;
         $display("FAIL lw_misaligned: got req=%0d mis=%b res=%h lat=%0d need req=0 mis=1 res=0 lat=1",
                  o.got_req, o.out_mis, o.out_result, o.out_lat);
      end
      t = mk(OP_STORE, 3'b001, 32'h100, 32'h2, 32'h1234CDEF, 32'h0);
      run_txn(t, o);
      checks++;
      if (!o.got_req || o.req_wstrb !== 4'b1100 || o.req_wdata !== 32'hCDEFCDEF || o.out_mis !== 1'b0) begin
         failures++;
         $display("FAIL sh_aligned: got req=%0d strb=%b wdata=%h mis=%b need 1 1100 cdefcdef 0",
                  o.got_req, o.req_wstrb, o.req_wdata, o.out_mis);
      end
   endtask

   task automatic test_bad_funct3();
      txn_t t; obs_t o;
      t = mk(OP_LOAD, 3'b011, 32'h40, 32'h0, 32'h0, 32'h5555);
      run_txn(t, o);
      checks++;
      if (o.got_req || o.out_result !== 32'h0 || o.out_mis !== 1'b0 || o.out_lat != 1) begin
         failures++;
         $display("FAIL bad_load_f3: got req=%0d res=%h mis=%b lat=%0d need 0 0 0 1",
                  o.got_req, o.out_result, o.out_mis, o.out_lat);
      end
      t = mk(OP_STORE, 3'b101, 32'h41, 32'h0, 32'h1, 32'h6666);
      run_txn(t, o);
      checks++;
      if (o.got_req || o.out_result !== 32'h0 || o.out_mis !== 1'b0) begin
         failures++;
         $display("FAIL bad_store_f3: got req=%0d res=%h mis=%b need 0 0 0", o.got_req, o.out_result, o.out_mis);
      end
   endtask

   task automatic test_stall();
      txn_t t; obs_t o;
      t = mk(OP_STORE, 3'b010, 32'h400, 32'h4, 32'hDEADBEEF, 32'h0);
      t.req_delay = 5; t.out_stall = 4;
      run_txn(t, o);
      checks++;
      if (!o.got_req || o.req_addr !== 32'h404 || o.req_wstrb !== 4'b1111 || o.req_wdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL stall_request: got addr=%h strb=%b wdata=%h need 00000404 1111 deadbeef",
                  o.req_addr, o.req_wstrb, o.req_wdata);
      end
      checks++;
      if (!o.stable_ok || !o.tready_ok || o.out_lat != 7) begin
         failures++;
         $display("FAIL stall_hold: got stable=%0d tready_ok=%0d lat=%0d need 1 1 7", o.stable_ok, o.tready_ok, o.out_lat);
      end
   endtask

   task automatic test_reset_mid();
      txn_t t; obs_t o;
      @(negedge clk);
      t = mk(OP_LOAD, 3'b010, 32'h300, 32'h0, 32'h0, 32'h0);
      in_instr = pack(t); rs1 = t.rs1; in_tvalid = 1'b1; out_tready = 1'b1;
      @(negedge clk);
      in_tvalid = 1'b0;
      checks++;
      if (req_valid !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_req: got %b need 1", req_valid);
      end
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
      @(negedge clk);
      rsp_valid = 1'b0;
      repeat (2) begin
         checks++;
         if (out_tvalid !== 1'b0 || req_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL rstmid_idle: got tv=%b rv=%b st=%0d need 0 0 %0d", out_tvalid, req_valid, dbg_state, ST_IDLE);
         end
         @(negedge clk);
      end
      t = mk(OP_ALU, 3'b000, 32'h1, 32'h0, 32'h2, 32'h3C);
      run_txn(t, o);
      checks++;
      if (!o.got_out || o.out_result !== 32'h3C || o.out_lat != 1) begin
         failures++;
         $display("FAIL rstmid_add: got res=%h lat=%0d need 0000003c 1", o.out_result, o.out_lat);
      end
   endtask

   task automatic test_back_to_back();
      txn_t t;
      logic [31:0] e;
      @(negedge clk);
      out_tready = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         if (i > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_tvalid !== 1'b1 || out_result !== e) begin
               failures++;
               $display("FAIL b2b_result[%0d]: got tv=%b res=%h need 1 %h", i, out_tvalid, out_result, e);
            end
         end
         if (i < 6) begin
            t = mk(OP_ALU_IMM, 3'(i), $urandom, $urandom, $urandom, $urandom);
            in_instr = pack(t); rs1 = t.rs1; rs2 = t.rs2; alu = t.alu; in_tvalid = 1'b1;
            exp_q.push_back(model(t).result);
            #1;
            checks++;
            if (in_tready !== 1'b1) begin
               failures++;
               $display("FAIL b2b_tready[%0d]: got %b need 1", i, in_tready);
            end
         end else begin
            in_tvalid = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (out_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain: got tv=%b need 0", out_tvalid);
      end
   endtask

   task automatic test_random();
      txn_t t; obs_t o; exp_t e;
      logic [6:0] ops [4];
      logic [31:0] want;
      ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_ALU; ops[3] = OP_LOAD;
      for (int n = 0; n < 40; n++) begin
         t = mk(ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), $urandom,
                32'($urandom_range(0, 15)) - 32'd8, $urandom, $urandom);
         t.rdata = $urandom; t.req_delay = $urandom_range(0, 3);
         t.rsp_delay = $urandom_range(1, 4); t.out_stall = $urandom_range(0, 2);
         e = model(t);
         exp_q.push_back(e.result);
         run_txn(t, o);
         want = exp_q.pop_front();
         checks++;
         if (!o.got_out || o.out_result !== want || o.out_mis !== e.mis ||
             o.out_instr !== pack(t) || o.out_lat != e.lat) begin
            failures++;
            $display("FAIL rand_out[%0d]: got out=%0d res=%h mis=%b lat=%0d need res=%h mis=%b lat=%0d",
                     n, o.got_out, o.out_result, o.out_mis, o.out_lat, want, e.mis, e.lat);
         end
         checks++;
         if (o.got_req != e.req ||
             (e.req && {o.req_write, o.req_addr, o.req_wdata, o.req_wstrb} !== {e.write, e.addr, e.wdata, e.wstrb})) begin
            failures++;
            $display("FAIL rand_req[%0d]: got req=%0d wr=%b addr=%h wd=%h strb=%b need req=%0d wr=%b addr=%h wd=%h strb=%b",
                     n, o.got_req, o.req_write, o.req_addr, o.req_wdata, o.req_wstrb,
                     e.req, e.write, e.addr, e.wdata, e.wstrb);
         end
         checks++;
         if (!o.stable_ok || !o.tready_ok || !o.drop_ok) begin
            failures++;
            $display("FAIL rand_protocol[%0d]: got stable=%0d tready_ok=%0d drop_ok=%0d need 1 1 1",
                     n, o.stable_ok, o.tready_ok, o.drop_ok);
         end
      end
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      test_reset();
      test_add();
      test_sb();
      test_lb_lbu();
      test_misaligned();
      test_bad_funct3();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stage4_memory.md
STAGE4_MEMORY -- requirements
Module: stage4_memory

Interface
REQ-001 No parameters; all data widths SHALL be common::REGISTER_WIDTH (32).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 axis_execute_to_memory  Axis.in  execute_to_memory_t  decoded_instruction, rs1_value, rs2_value, alu_result, branch_taken, branch_target.
REQ-005 axis_memory_to_writeback  Axis.out  memory_to_writeback_t  decoded_instruction, result, misaligned.
REQ-006 dmem_req_valid  out  1  data-memory request valid.
REQ-007 dmem_req_ready  in  1  memory accepts request.
REQ-008 dmem_req_write  out  1  1 = store, 0 = load.
REQ-009 dmem_req_addr  out  32  word-aligned address (addr[1:0] = 0).
REQ-010 dmem_req_wdata  out  32  store data, lane-shifted.
REQ-011 dmem_req_wstrb  out  4  byte enables; 0 for loads.
REQ-012 dmem_rsp_valid  in  1  single-cycle load response strobe.
REQ-013 dmem_rsp_rdata  in  32  load response word.

Function
REQ-014 Effective address SHALL be rs1_value + decoded_instruction.immediate, modulo 2^32.
REQ-015 FSM states SHALL be IDLE, REQ, WAIT_RSP, OUT.
REQ-016 upstream tready SHALL be 1 only in IDLE with output slot free (tvalid=0 or downstream tready=1).
REQ-017 Non-memory opcode accepted in IDLE: output tvalid next cycle, result=alu_result, state stays IDLE (1-cycle latency, full throughput).
REQ-018 Aligned OP_LOAD/OP_STORE accepted: IDLE->REQ; dmem_req_valid asserted next cycle, held stable with addr/wdata/wstrb until dmem_req_ready.
REQ-019 Store handshake: REQ->OUT; tvalid next cycle, result=0.
REQ-020 Load handshake: REQ->WAIT_RSP; on dmem_rsp_valid capture data and move to OUT.
REQ-021 dmem_rsp_valid in same cycle as handshake SHALL NOT be honoured; responses only count in WAIT_RSP.
REQ-022 OUT asserts tvalid; OUT->IDLE when downstream tready=1.
REQ-023 Load funct3: LB 000, LH 001 sign-extend; LW 010; LBU 100, LHU 101 zero-extend; lane chosen by addr[1:0].
REQ-024 Store funct3: SB wstrb=0001<<addr[1:0], byte replicated x4; SH wstrb=0011<<addr[1:0], half replicated x2; SW wstrb=1111.
REQ-025 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no dmem request; output next cycle with misaligned=1, result=0.
REQ-026 Undefined funct3 for load/store: treated as non-memory, result=0, misaligned=0.
REQ-027 While output tvalid=1 and downstream tready=0, tdata SHALL hold stable.
REQ-028 Upstream tvalid=0 in IDLE: no state change; output tvalid drops after downstream accepts.

Reset
REQ-029 rst SHALL force IDLE, output tvalid=0, dmem_req_valid=0, dmem_req_write=0, dmem_req_wstrb=0, misaligned=0.
REQ-030 rst mid REQ/WAIT_RSP SHALL abandon the access; a later dmem_rsp_valid in IDLE SHALL be ignored.

Structure
REQ-031 memory_to_writeback_t and load/store funct3 enums (LB..LHU, SB..SW) SHALL live in package common.
REQ-032 Lane alignment/extension logic SHALL be sub-module load_store_align (combinational: addr[1:0], funct3, wdata/rdata -> wdata, wstrb, rdata_ext).

Verification
REQ-033 ADD alu_result=0x12, downstream tready=1 -> tvalid next cycle, result=0x12, dmem_req_valid never 1.
REQ-034 SB rs1=0x100, imm=3, rs2=0xAB -> addr 0x100, wstrb 1000, wdata 0xABABABAB; output after handshake, result=0.
REQ-035 LB addr 0x202, rdata 0x00800000, rsp 3 cycles after handshake -> result 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 LW addr 0x101 -> no dmem request, misaligned=1 next cycle; SH addr 0x102 -> wstrb 1100, no misaligned.
REQ-037 dmem_req_ready held 0 for 5 cycles then downstream tready 0 for 4 cycles -> request and output payload stable, upstream tready=0 throughout.
REQ-038 rst in WAIT_RSP, then dmem_rsp_valid -> no output tvalid, FSM IDLE, next ADD completes normally.
